axil_master_bridge: RTL and testbench

Single-outstanding AXI-Lite initiator that turns a simple command/response handshake into AXI-Lite write and read transactions toward the FIR configuration port. It sits between the host-side sequencer (tap loading, length programming, ap_start, ap_done polling) and the FIR's AXI-Lite responder. It uses the same AW/W/AR/R channel subset as the FIR and has no B channel. It adds a per-transaction timeout so a hung responder cannot lock the sequencer.

---
 rtl/fir_pkg.sv | 21 ++
 rtl/axil_timeout_cnt.sv | 29 ++
 rtl/axil_master_bridge.sv | 168 ++++++++++++++++
 tb/tb_axil_master_bridge.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR configuration path: bridge state encoding,
// FIR AXI-Lite register map and ap_ctrl bit positions.
package fir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ADDR,
    RD_DATA,
    RESP
  } axil_state_e;

  localparam logic [11:0] AP_CTRL_ADDR  = 12'h000;
  localparam logic [11:0] DATA_LEN_ADDR = 12'h010;
  localparam logic [11:0] TAP_BASE_ADDR = 12'h020;

  localparam int AP_START_BIT = 0;
  localparam int AP_DONE_BIT  = 1;
  localparam int AP_IDLE_BIT  = 2;

endpackage

// File: rtl/axil_timeout_cnt.sv
// Per-transaction wait counter; expired is high on the pTIMEOUT-th cycle
// spent waiting, so the bridge gives up on the edge that ends that cycle.
module axil_timeout_cnt #(
  parameter int pTIMEOUT = 255
) (
  input  logic axis_clk,
  input  logic axis_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = (pTIMEOUT > 1) ? $clog2(pTIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(pTIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Saturates at LIMIT so a stalled enable can never wrap back to zero.
  always_ff @(posedge axis_clk) begin
    if (axis_rst || clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/axil_master_bridge.sv
// Single-outstanding AXI-Lite initiator: turns cmd/rsp handshakes into
// AW/W or AR/R transactions toward the FIR, with a per-transaction timeout.
module axil_master_bridge
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int pTIMEOUT    = 255
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [pADDR_WIDTH-1:0] cmd_addr,
  input  logic [pDATA_WIDTH-1:0] cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [pDATA_WIDTH-1:0] rsp_rdata,
  output logic                   rsp_err,
  output logic                   busy,
  output logic                   awvalid,
  output logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   awready,
  output logic                   wvalid,
  output logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   wready,
  output logic                   arvalid,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   arready,
  input  logic                   rvalid,
  input  logic [pDATA_WIDTH-1:0] rdata,
  output logic                   rready
);

  axil_state_e state;
  logic aw_done;
  logic w_done;
  logic aw_hs;
  logic w_hs;
  logic wr_complete;
  logic cnt_clear;
  logic cnt_en;
  logic expired;

  assign aw_hs       = aw_done || (awvalid && awready);
  assign w_hs        = w_done  || (wvalid && wready);
  assign wr_complete = aw_hs && w_hs;
  assign cnt_clear   = (state == IDLE);
  assign cnt_en      = (state == WRITE) || (state == RD_ADDR) || (state == RD_DATA);

  axil_timeout_cnt #(
    .pTIMEOUT(pTIMEOUT)
  ) u_timeout (
    .axis_clk(axis_clk),
    .axis_rst(axis_rst),
    .clear   (cnt_clear),
    .enable  (cnt_en),
    .expired (expired)
  );

  // araddr is only loaded on command acceptance: the FIR drives rdata
  // combinationally from it, so it must not move until the next read.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state     <= IDLE;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      arvalid   <= 1'b0;
      rready    <= 1'b0;
      awaddr    <= '0;
      wdata     <= '0;
      araddr    <= '0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            if (cmd_write) begin
              awaddr  <= cmd_addr;
              wdata   <= cmd_wdata;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state   <= WRITE;
            end else begin
              araddr  <= cmd_addr;
              arvalid <= 1'b1;
              state   <= RD_ADDR;
            end
          end
        end
        WRITE: begin
          if (awvalid && awready) begin
            awvalid <= 1'b0;
            aw_done <= 1'b1;
          end
          if (wvalid && wready) begin
            wvalid <= 1'b0;
            w_done <= 1'b1;
          end
          if (wr_complete) begin
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            state     <= RESP;
          end else if (expired) begin
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= RESP;
          end
        end
        RD_ADDR: begin
          if (expired) begin
            arvalid   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= RESP;
          end else if (arvalid && arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid) begin
            rready    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            rsp_rdata <= rdata;
            state     <= RESP;
          end else if (expired) begin
            rready    <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_master_bridge.sv
// Bench for axil_master_bridge: a latency-programmable FIR responder plus a
// transaction-level reference model of latency, error and read data.
module tb_axil_master_bridge;
  import fir_pkg::*;

  localparam int PT = 8;

  logic        axis_clk = 1'b0;
  logic        axis_rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [11:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;
  logic        awvalid, awready;
  logic [11:0] awaddr;
  logic        wvalid, wready;
  logic [31:0] wdata;
  logic        arvalid, arready;
  logic [11:0] araddr;
  logic        rvalid = 1'b0;
  logic [31:0] rdata;
  logic        rready;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 axis_clk = ~axis_clk;

  axil_master_bridge #(
    .pADDR_WIDTH(12),
    .pDATA_WIDTH(32),
    .pTIMEOUT   (PT)
  ) dut (
    .axis_clk (axis_clk),
    .axis_rst (axis_rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .awvalid  (awvalid),
    .awaddr   (awaddr),
    .awready  (awready),
    .wvalid   (wvalid),
    .wdata    (wdata),
    .wready   (wready),
    .arvalid  (arvalid),
    .araddr   (araddr),
    .arready  (arready),
    .rvalid   (rvalid),
    .rdata    (rdata),
    .rready   (rready)
  );

  // FIR responder: each ready rises after its valid has waited *_lat cycles.
  int          aw_lat = 0, w_lat = 0, ar_lat = 0;
  logic        ar_block = 1'b0;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  logic [31:0] fir_mem [0:1023] = '{0: 32'h4, default: 32'h0};
  logic        aw_got = 1'b0, w_got = 1'b0;
  logic [11:0] got_addr = '0;
  logic [31:0] got_data = '0;
  logic [11:0] mem_waddr;
  logic [31:0] mem_wdata;

  assign awready = awvalid && (aw_cnt >= aw_lat);
  assign wready  = wvalid && (w_cnt >= w_lat);
  assign arready = arvalid && !ar_block && (ar_cnt >= ar_lat);
  assign rdata   = fir_mem[araddr[11:2]];

  always_comb begin
    mem_waddr = aw_got ? got_addr : awaddr;
    mem_wdata = w_got ? got_data : wdata;
  end

  always @(posedge axis_clk) begin
    aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
    w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
    ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
    rvalid <= (axis_rst || !busy) ? 1'b0 : ((arvalid && arready) || (rvalid && !rready));
    if (axis_rst || !busy) begin
      aw_got <= 1'b0;
      w_got  <= 1'b0;
    end else begin
      if (awvalid && awready) begin
        aw_got   <= 1'b1;
        got_addr <= awaddr;
      end
      if (wvalid && wready) begin
        w_got    <= 1'b1;
        got_data <= wdata;
      end
      if ((aw_got || (awvalid && awready)) && (w_got || (wvalid && wready)))
        fir_mem[mem_waddr[11:2]] <= mem_wdata;
    end
  end

  // Reference register contents as seen by the host.
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] ref_read(input logic [11:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return (a == AP_CTRL_ADDR) ? 32'h4 : 32'h0;
  endfunction

  typedef struct packed {
    int          lat;
    int          aw_hi;
    int          w_hi;
    int          ar_hi;
    logic [31:0] rdata;
    logic        err;
    logic        araddr_stable;
    logic [11:0] awaddr_c1;
    logic [31:0] wdata_c1;
    logic        hung;
  } obs_t;

  task automatic run_txn(input logic wr, input logic [11:0] addr, input logic [31:0] wd,
                         output obs_t o);
    int guard;
    o = '0;
    o.araddr_stable = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(posedge axis_clk); #1;
      guard++;
    end
    if (!cmd_ready) o.hung = 1'b1;
    @(posedge axis_clk); #1;
    cmd_valid = 1'b0;
    o.awaddr_c1 = awaddr;
    o.wdata_c1  = wdata;
    o.lat = 1;
    while (!rsp_valid && o.lat < 100) begin
      if (awvalid) o.aw_hi = o.aw_hi + 1;
      if (wvalid)  o.w_hi  = o.w_hi + 1;
      if (arvalid) o.ar_hi = o.ar_hi + 1;
      if (!wr && araddr !== addr) o.araddr_stable = 1'b0;
      @(posedge axis_clk); #1;
      o.lat = o.lat + 1;
    end
    if (!rsp_valid) o.hung = 1'b1;
    if (!wr && araddr !== addr) o.araddr_stable = 1'b0;
    o.rdata = rsp_rdata;
    o.err   = rsp_err;
    rsp_ready = 1'b1;
    @(posedge axis_clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    axis_rst = 1'b1;
    repeat (3) @(posedge axis_clk);
    #1;
    n_cmp++;
    if ({cmd_ready, busy, rsp_valid, rsp_err} !== 4'b1000) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: got ready/busy/rsp_valid/err=%b expected 1000",
               {cmd_ready, busy, rsp_valid, rsp_err});
    end
    n_cmp++;
    if ({awvalid, wvalid, arvalid, rready} !== 4'b0000) begin
      n_fail++;
      $display("[TB] FAIL reset_axi: got aw/w/ar/rready=%b expected 0000",
               {awvalid, wvalid, arvalid, rready});
    end
    n_cmp++;
    if ({rsp_rdata, awaddr, araddr, wdata} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_data: got rdata=%h awaddr=%h araddr=%h wdata=%h expected all 0",
               rsp_rdata, awaddr, araddr, wdata);
    end
    axis_rst = 1'b0;
  endtask

  task automatic test_write_basic();
    obs_t o;
    aw_lat = 0; w_lat = 0;
    run_txn(1'b1, DATA_LEN_ADDR, 32'd600, o);
    ref_mem[int'(DATA_LEN_ADDR)] = 32'd600;
    n_cmp++;
    if (o.awaddr_c1 !== DATA_LEN_ADDR) begin
      n_fail++;
      $display("[TB] FAIL wr_awaddr: got %h expected %h", o.awaddr_c1, DATA_LEN_ADDR);
    end
    n_cmp++;
    if (o.wdata_c1 !== 32'd600) begin
      n_fail++;
      $display("[TB] FAIL wr_wdata: got %0d expected 600", o.wdata_c1);
    end
    n_cmp++;
    if (o.lat !== 2) begin
      n_fail++;
      $display("[TB] FAIL wr_latency: got %0d expected 2", o.lat);
    end
    n_cmp++;
    if ({o.err, o.rdata} !== 33'h0) begin
      n_fail++;
      $display("[TB] FAIL wr_rsp: got err=%b rdata=%h expected 0/0", o.err, o.rdata);
    end
  endtask

  task automatic test_wready_delay();
    obs_t o;
    aw_lat = 0; w_lat = 3;
    run_txn(1'b1, TAP_BASE_ADDR, 32'hCAFE_0001, o);
    ref_mem[int'(TAP_BASE_ADDR)] = 32'hCAFE_0001;
    n_cmp++;
    if (o.aw_hi !== 1) begin
      n_fail++;
      $display("[TB] FAIL wdly_awvalid_cycles: got %0d expected 1", o.aw_hi);
    end
    n_cmp++;
    if (o.w_hi !== 4) begin
      n_fail++;
      $display("[TB] FAIL wdly_wvalid_cycles: got %0d expected 4", o.w_hi);
    end
    n_cmp++;
    if (o.lat !== 5 || o.err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL wdly_rsp: got lat=%0d err=%b expected 5/0", o.lat, o.err);
    end
    w_lat = 0;
  endtask

  task automatic test_read_idle();
    obs_t o;
    ar_lat = 0;
    run_txn(1'b0, AP_CTRL_ADDR, 32'h0, o);
    n_cmp++;
    if (o.rdata !== 32'h4 || o.err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rd_ctrl_data: got rdata=%h err=%b expected 4/0", o.rdata, o.err);
    end
    n_cmp++;
    if (o.lat !== 3) begin
      n_fail++;
      $display("[TB] FAIL rd_latency: got %0d expected 3", o.lat);
    end
    n_cmp++;
    if (o.araddr_stable !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL rd_araddr_stable: got %b expected 1", o.araddr_stable);
    end
  endtask

  task automatic test_read_timeout();
    obs_t o;
    ar_block = 1'b1;
    run_txn(1'b0, AP_CTRL_ADDR, 32'h0, o);
    ar_block = 1'b0;
    n_cmp++;
    if (o.ar_hi !== PT) begin
      n_fail++;
      $display("[TB] FAIL to_arvalid_cycles: got %0d expected %0d", o.ar_hi, PT);
    end
    n_cmp++;
    if (o.err !== 1'b1 || o.rdata !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL to_rsp: got err=%b rdata=%h expected 1/0", o.err, o.rdata);
    end
    n_cmp++;
    if (o.lat !== PT + 1) begin
      n_fail++;
      $display("[TB] FAIL to_latency: got %0d expected %0d", o.lat, PT + 1);
    end
  endtask

  task automatic test_rsp_backpressure();
    int guard;
    ar_lat = 0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = AP_CTRL_ADDR;
    guard = 0;
    while (!cmd_ready && guard < 50) begin @(posedge axis_clk); #1; guard++; end
    @(posedge axis_clk); #1;
    guard = 0;
    while (!rsp_valid && guard < 50) begin @(posedge axis_clk); #1; guard++; end
    for (int c = 0; c < 5; c++) begin
      n_cmp++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h4 || cmd_ready !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL bp_hold cycle %0d: got valid=%b rdata=%h cmd_ready=%b expected 1/4/0",
                 c, rsp_valid, rsp_rdata, cmd_ready);
      end
      @(posedge axis_clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge axis_clk); #1;
    rsp_ready = 1'b0;
    n_cmp++;
    if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
      n_fail++;
      $display("[TB] FAIL bp_after_hs: got valid/cmd_ready/busy=%b expected 010",
               {rsp_valid, cmd_ready, busy});
    end
    @(posedge axis_clk); #1;
    cmd_valid = 1'b0;
    n_cmp++;
    if ({cmd_ready, busy} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL bp_next_accept: got cmd_ready/busy=%b expected 01", {cmd_ready, busy});
    end
    guard = 0;
    while (!rsp_valid && guard < 50) begin @(posedge axis_clk); #1; guard++; end
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h4) begin
      n_fail++;
      $display("[TB] FAIL bp_second_rsp: got valid=%b rdata=%h expected 1/4", rsp_valid, rsp_rdata);
    end
    rsp_ready = 1'b1;
    @(posedge axis_clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    obs_t o;
    int guard;
    aw_lat = 0; w_lat = 6;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 12'h024; cmd_wdata = 32'hDEAD_BEEF;
    guard = 0;
    while (!cmd_ready && guard < 50) begin @(posedge axis_clk); #1; guard++; end
    @(posedge axis_clk); #1;
    cmd_valid = 1'b0;
    @(posedge axis_clk); #1;
    axis_rst = 1'b1;
    @(posedge axis_clk); #1;
    axis_rst = 1'b0;
    n_cmp++;
    if ({awvalid, wvalid, arvalid, busy, cmd_ready} !== 5'b00001) begin
      n_fail++;
      $display("[TB] FAIL rst_mid: got aw/w/ar/busy/cmd_ready=%b expected 00001",
               {awvalid, wvalid, arvalid, busy, cmd_ready});
    end
    w_lat = 0;
    run_txn(1'b1, 12'h028, 32'h1234_5678, o);
    ref_mem[32'h028] = 32'h1234_5678;
    n_cmp++;
    if (o.lat !== 2 || o.err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rst_fresh_write: got lat=%0d err=%b expected 2/0", o.lat, o.err);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin : txn
      obs_t        o;
      logic        wr;
      logic [11:0] a;
      logic [31:0] d;
      logic [31:0] exp_rd;
      logic        exp_err;
      int          wait_cyc;
      int          exp_lat;
      wr       = 1'($urandom_range(0, 1));
      a        = 12'($urandom_range(4, 15) * 4);
      d        = $urandom;
      aw_lat   = $urandom_range(0, 9);
      w_lat    = $urandom_range(0, 9);
      ar_lat   = $urandom_range(0, 8);
      ar_block = ($urandom_range(0, 9) == 0);
      if (wr) wait_cyc = 1 + ((aw_lat > w_lat) ? aw_lat : w_lat);
      else    wait_cyc = ar_block ? 1000 : 2 + ar_lat;
      exp_err = (wait_cyc > PT);
      exp_lat = (exp_err ? PT : wait_cyc) + 1;
      exp_rd  = (wr || exp_err) ? 32'h0 : ref_read(a);
      run_txn(wr, a, d, o);
      if (wr && !exp_err) ref_mem[int'(a)] = d;
      n_cmp++;
      if (o.lat !== exp_lat) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_latency: got %0d expected %0d", i, o.lat, exp_lat);
      end
      n_cmp++;
      if (o.err !== exp_err) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_err: got %b expected %b", i, o.err, exp_err);
      end
      n_cmp++;
      if (o.rdata !== exp_rd) begin
        n_fail++;
        $display("[TB] FAIL rand%0d_rdata: got %h expected %h", i, o.rdata, exp_rd);
      end
    end
    ar_block = 1'b0;
    aw_lat = 0; w_lat = 0; ar_lat = 0;
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_wready_delay();
    test_read_idle();
    test_read_timeout();
    test_rsp_backpressure();
    test_reset_mid_write();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
